apb_reg_slave: RTL and testbench

APB completer that answers transfers issued by the testbench APB master tasks on the shared APB bus. It holds a small word-addressed register file, inserts a configurable number of wait states, and drives PREADY/PRDATA back to the master. It serves as the default bus target in the APB BFM environment and exposes its register contents to downstream logic.

---
 rtl/apb_reg_slave_if.sv | 38 +++
 rtl/apb_reg_slave.sv | 140 ++++++++++++++
 tb/tb_apb_reg_slave.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle shared by the BFM master tasks and the register completer.
// Signals:
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA - driven by the master
//   PREADY, PRDATA                       - driven by the completer
interface apb_reg_slave_if #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
) ();

    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic                      PREADY;
    logic [APB_DATA_WIDTH-1:0] PRDATA;

    modport master (
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PREADY,
        input  PRDATA
    );

    modport slave (
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PREADY,
        output PRDATA
    );

endinterface

// File: rtl/apb_reg_slave.sv
// APB completer with a small word-addressed register file and configurable wait states.
// Word 0 is a read-only ID word; words 1..NUM_REGS-1 are read/write.
// Ports:
//   apbClk - bus clock, all state changes on its rising edge
//   rst    - synchronous active-high reset
//   apb    - APB bus (slave side): PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PREADY/PRDATA out
//   regs_o - flattened register contents, word i at [i*APB_DATA_WIDTH +: APB_DATA_WIDTH]
module apb_reg_slave #(
    parameter int unsigned             APB_ADDR_WIDTH = 32,
    parameter int unsigned             APB_DATA_WIDTH = 32,
    parameter int unsigned             NUM_REGS       = 8,
    parameter int unsigned             WAIT_STATES    = 0,
    parameter logic [APB_DATA_WIDTH-1:0] ID_VALUE     = 32'hA9B0_0001
) (
    input  logic                               apbClk,
    input  logic                               rst,
    apb_reg_slave_if.slave                     apb,
    output logic [NUM_REGS*APB_DATA_WIDTH-1:0] regs_o
);

    localparam int unsigned IdxW     = $clog2(NUM_REGS);
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic                      in_range_q, in_range_d;
    logic                      write_q, write_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      pready_q, pready_d;
    logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [APB_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [APB_DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Decode of the address currently on the bus (used at the setup edge).
    logic [IdxW-1:0]           req_idx;
    logic                      req_in_range;
    logic [APB_DATA_WIDTH-1:0] req_rdata;
    logic [APB_DATA_WIDTH-1:0] lat_rdata;
    logic                      unused_addr_lsbs;

    assign req_idx          = apb.PADDR[2 +: IdxW];
    // Upper address bits above the word index must all be zero to hit the file.
    assign req_in_range     = (apb.PADDR[APB_ADDR_WIDTH-1:IdxW+2] == '0);
    assign unused_addr_lsbs = ^apb.PADDR[1:0];

    // Read data for a transfer: 0 for writes and out-of-range addresses.
    assign req_rdata = (apb.PWRITE || !req_in_range) ? '0 : regs_q[req_idx];
    assign lat_rdata = (write_q || !in_range_q) ? '0 : regs_q[idx_q];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        write_d    = write_q;
        cnt_d      = cnt_q;
        pready_d   = pready_q;
        prdata_d   = prdata_q;
        regs_d     = regs_q;
        regs_d[0]  = ID_VALUE;

        unique case (state_q)
            StIdle: begin
                // PENABLE without a preceding setup phase is ignored here.
                if (apb.PSEL && !apb.PENABLE) begin
                    state_d    = StAccess;
                    idx_d      = req_idx;
                    in_range_d = req_in_range;
                    write_d    = apb.PWRITE;
                    cnt_d      = WaitInit;
                    // Zero wait states: PREADY/PRDATA valid in the first ACCESS cycle.
                    if (WAIT_STATES == 0) begin
                        pready_d = 1'b1;
                        prdata_d = req_rdata;
                    end
                end
            end
            StAccess: begin
                if (!apb.PSEL) begin
                    // Master abandoned the transfer: no register update.
                    state_d  = StIdle;
                    cnt_d    = '0;
                    pready_d = 1'b0;
                    prdata_d = '0;
                end else if (pready_q && apb.PENABLE) begin
                    if (write_q && in_range_q && (idx_q != '0)) begin
                        regs_d[idx_q] = apb.PWDATA;
                    end
                    state_d  = StIdle;
                    pready_d = 1'b0;
                    prdata_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                    // Last wait cycle: raise PREADY together with the read data.
                    if (cnt_q == 4'd1) begin
                        pready_d = 1'b1;
                        prdata_d = lat_rdata;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge apbClk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            write_q    <= 1'b0;
            cnt_q      <= '0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
            regs_q[0]  <= ID_VALUE;
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            write_q    <= write_d;
            cnt_q      <= cnt_d;
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
            regs_q     <= regs_d;
        end
    end

    assign apb.PREADY = pready_q;
    assign apb.PRDATA = prdata_q;

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
        assign regs_o[g*APB_DATA_WIDTH +: APB_DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: three instances with 0, 3 and 2 wait states share
// one master driver; the selected instance sees PSEL/PENABLE, the others stay idle.
module tb_apb_reg_slave;

    localparam logic [31:0] IdVal = 32'hA9B0_0001;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    int          sel;

    logic [255:0] regs0, regs1, regs2;

    apb_reg_slave_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus0 ();
    apb_reg_slave_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus1 ();
    apb_reg_slave_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus2 ();

    assign bus0.PSEL    = psel && (sel == 0);
    assign bus0.PENABLE = penable && (sel == 0);
    assign bus0.PWRITE  = pwrite;
    assign bus0.PADDR   = paddr;
    assign bus0.PWDATA  = pwdata;
    assign bus1.PSEL    = psel && (sel == 1);
    assign bus1.PENABLE = penable && (sel == 1);
    assign bus1.PWRITE  = pwrite;
    assign bus1.PADDR   = paddr;
    assign bus1.PWDATA  = pwdata;
    assign bus2.PSEL    = psel && (sel == 2);
    assign bus2.PENABLE = penable && (sel == 2);
    assign bus2.PWRITE  = pwrite;
    assign bus2.PADDR   = paddr;
    assign bus2.PWDATA  = pwdata;

    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(IdVal)) u_dut0 (
        .apbClk (clk),
        .rst    (rst),
        .apb    (bus0),
        .regs_o (regs0)
    );
    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(IdVal)) u_dut1 (
        .apbClk (clk),
        .rst    (rst),
        .apb    (bus1),
        .regs_o (regs1)
    );
    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(2), .ID_VALUE(IdVal)) u_dut2 (
        .apbClk (clk),
        .rst    (rst),
        .apb    (bus2),
        .regs_o (regs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    logic [31:0] model[3][8];
    int          wait_of[3] = '{0, 3, 2};
    int          prdy_cnt[3] = '{0, 0, 0};
    int          done_cnt[3] = '{0, 0, 0};
    int          checks = 0;
    int          errors = 0;

    // PREADY cycles seen at each edge; must equal completed transfers.
    always @(posedge clk) begin
        if (bus0.PREADY) prdy_cnt[0]++;
        if (bus1.PREADY) prdy_cnt[1]++;
        if (bus2.PREADY) prdy_cnt[2]++;
    end

    function automatic logic pready_of(input int d);
        case (d)
            0:       return bus0.PREADY;
            1:       return bus1.PREADY;
            default: return bus2.PREADY;
        endcase
    endfunction

    function automatic logic [31:0] prdata_of(input int d);
        case (d)
            0:       return bus0.PRDATA;
            1:       return bus1.PRDATA;
            default: return bus2.PRDATA;
        endcase
    endfunction

    function automatic logic [31:0] word_of(input int d, input int i);
        case (d)
            0:       return regs0[i*32 +: 32];
            1:       return regs1[i*32 +: 32];
            default: return regs2[i*32 +: 32];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) model[d][i] = (i == 0) ? IdVal : 32'h0;
        end
    endtask

    task automatic add(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp);
        vec_t v;
        v.dut = d; v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = exp;
        vecs.push_back(v);
    endtask

    // One complete transfer; entered and left at posedge+1 so consecutive calls are zero-gap.
    task automatic apb_xfer(input int d, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd);
        int          waits;
        int          ix;
        bit          hit;
        logic [31:0] exp;
        ix  = int'(a[4:2]);
        hit = (a < 32'h20);
        sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        sb_q.push_back(exp_rd);
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (!pready_of(d) && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        exp = sb_q.pop_front();
        if (!pready_of(d)) begin
            checks++; errors++;
            $display("FAIL pready_timeout dut%0d addr %h: PREADY never rose", d, a);
        end else begin
            chk($sformatf("wait_cycles dut%0d addr %h", d, a), 32'(waits), 32'(wait_of[d]));
            chk($sformatf("prdata dut%0d addr %h", d, a), prdata_of(d), exp);
            // Write must not be visible before the completion edge.
            chk($sformatf("word_before_commit dut%0d idx %0d", d, ix), word_of(d, ix),
                model[d][ix]);
            @(posedge clk); #1;
            done_cnt[d]++;
            if (wr && hit && ix != 0) model[d][ix] = wd;
            chk($sformatf("pready_after dut%0d addr %h", d, a), 32'(pready_of(d)), 32'h0);
            chk($sformatf("prdata_after dut%0d addr %h", d, a), prdata_of(d), 32'h0);
            chk($sformatf("word_after dut%0d idx %0d", d, ix), word_of(d, ix), model[d][ix]);
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_pready dut%0d", d), 32'(pready_of(d)), 32'h0);
            chk($sformatf("reset_prdata dut%0d", d), prdata_of(d), 32'h0);
            chk($sformatf("reset_word0 dut%0d", d), word_of(d, 0), IdVal);
            chk($sformatf("reset_word3 dut%0d", d), word_of(d, 3), 32'h0);
        end

        // Zero-wait instance, then the 3-wait instance; entries run back to back.
        add(0, 0, 32'h00, 32'h0,         IdVal);
        add(0, 0, 32'h04, 32'h0,         32'h0);
        add(0, 1, 32'h04, 32'h1234_5678, 32'h0);
        add(0, 1, 32'h1C, 32'hCAFE_F00D, 32'h0);
        add(0, 0, 32'h04, 32'h0,         32'h1234_5678);
        add(0, 0, 32'h1C, 32'h0,         32'hCAFE_F00D);
        add(0, 1, 32'h00, 32'hFFFF_FFFF, 32'h0);
        add(0, 0, 32'h00, 32'h0,         IdVal);
        add(0, 1, 32'h20, 32'h5555_5555, 32'h0);
        add(0, 0, 32'h20, 32'h0,         32'h0);
        add(0, 1, 32'h24, 32'hDEAD_BEEF, 32'h0);
        add(0, 0, 32'h04, 32'h0,         32'h1234_5678);
        add(0, 1, 32'h06, 32'h0BAD_BEEF, 32'h0);
        add(0, 0, 32'h04, 32'h0,         32'h0BAD_BEEF);
        add(0, 0, 32'h1F, 32'h0,         32'hCAFE_F00D);
        add(0, 0, 32'h100, 32'h0,        32'h0);
        add(0, 1, 32'h04, 32'h0000_1111, 32'h0);
        add(0, 1, 32'h08, 32'h0000_2222, 32'h0);
        add(0, 0, 32'h04, 32'h0,         32'h0000_1111);
        add(0, 0, 32'h08, 32'h0,         32'h0000_2222);
        add(1, 1, 32'h08, 32'h0000_00A5, 32'h0);
        add(1, 0, 32'h08, 32'h0,         32'h0000_00A5);
        add(1, 0, 32'h00, 32'h0,         IdVal);

        foreach (vecs[k]) begin
            apb_xfer(vecs[k].dut, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rd);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("regs_o dut0 word%0d", i), word_of(0, i), model[0][i]);
        end
        chk("regs_o dut0 word7 literal", word_of(0, 7), 32'hCAFE_F00D);

        // Abort: drop PSEL while the 2-wait instance is still counting.
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("abort_pready", 32'(pready_of(2)), 32'h0);
        chk("abort_word3", word_of(2, 3), 32'h0);
        @(posedge clk); #1;
        apb_xfer(2, 0, 32'h0C, 32'h0, 32'h0);

        // Reset in the middle of a write transfer.
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        chk("rst_mid_pready", 32'(pready_of(2)), 32'h0);
        chk("rst_mid_word4", word_of(2, 4), 32'h0);
        @(posedge clk); #1;
        chk("rst_mid_word4_later", word_of(2, 4), 32'h0);
        chk("rst_clears_dut0_word1", word_of(0, 1), 32'h0);
        chk("rst_clears_dut1_word2", word_of(1, 2), 32'h0);
        apb_xfer(2, 0, 32'h10, 32'h0, 32'h0);
        apb_xfer(0, 0, 32'h1C, 32'h0, 32'h0);

        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("pready_once_per_xfer dut%0d", d), 32'(prdy_cnt[d]),
                32'(done_cnt[d]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
